// File: rtl/arith_pkg.sv
// ============================================================================
// Module      : arith_pkg
// Description : Shared types and constants for the arithmetic unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package arith_pkg;

    localparam int c_DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage : arith_pkg

`default_nettype wire

// File: rtl/fa.sv
// ============================================================================
// Module      : fa
// Description : Combinational 1-bit full adder slice.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fa (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);

endmodule : fa

`default_nettype wire

// File: rtl/serial_add_ctrl.sv
// ============================================================================
// Module      : serial_add_ctrl
// Description : Bit-serial add/subtract sequencer around one full-adder slice,
//               LSB-first, one bit per clock, done strobe on completion.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_add_ctrl
    import arith_pkg::*;
#(
    parameter int WIDTH = c_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             co
);

    localparam int c_CNT_W = $clog2(WIDTH);
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(WIDTH - 1);

    state_t             r_state;
    logic [WIDTH-1:0]   r_shift_a;
    logic [WIDTH-1:0]   r_shift_b;
    logic [WIDTH-2:0]   r_result;
    logic               r_carry;
    logic [c_CNT_W-1:0] r_cnt;

    logic               w_sum;
    logic               w_cout;
    logic               w_accept;
    logic [WIDTH-1:0]   w_result_nxt;

    fa u_fa (
        .a  (r_shift_a[0]),
        .b  (r_shift_b[0]),
        .ci (r_carry),
        .s  (w_sum),
        .co (w_cout)
    );

    assign w_accept = start && ((r_state == IDLE) || (r_state == DONE));

    // The result register keeps only the upper WIDTH-1 bits; the bit that
    // would shift out of its LSB is never needed.
    assign w_result_nxt = {w_sum, r_result};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_shift_a <= '0;
            r_shift_b <= '0;
            r_result  <= '0;
            r_carry   <= 1'b0;
            r_cnt     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            s         <= '0;
            co        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE, DONE: begin
                    r_state <= IDLE;
                    if (w_accept) begin
                        r_shift_a <= a;
                        r_shift_b <= sub ? ~b : b;
                        r_carry   <= sub ? 1'b1 : ci;
                        r_result  <= '0;
                        r_cnt     <= '0;
                        busy      <= 1'b1;
                        r_state   <= RUN;
                    end
                end
                RUN: begin
                    r_shift_a <= r_shift_a >> 1;
                    r_shift_b <= r_shift_b >> 1;
                    r_carry   <= w_cout;
                    r_result  <= w_result_nxt[WIDTH-1:1];
                    r_cnt     <= r_cnt + 1'b1;
                    if (r_cnt == c_LAST) begin
                        // Final MSB slice: publish straight from the slice
                        // output so s/co land on the same edge as done.
                        s       <= w_result_nxt;
                        co      <= w_cout;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= DONE;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule : serial_add_ctrl

`default_nettype wire

// File: tb/tb_serial_add_ctrl.sv
// ============================================================================
// Module      : tb_serial_add_ctrl
// Description : Directed self-checking bench for serial_add_ctrl (WIDTH=4)
//               with a cycle-level behavioural reference.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_add_ctrl;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         sub;
    logic         ci;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] s;
    logic         co;

    int n_tests = 0;
    int n_fail  = 0;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .sub   (sub),
        .a     (a),
        .b     (b),
        .ci    (ci),
        .busy  (busy),
        .done  (done),
        .s     (s),
        .co    (co)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: an accepted request yields its arithmetic result W edges
    // later; busy covers the gap, done marks the single publishing cycle.
    int           m_left;
    logic         m_busy;
    logic         m_done;
    logic [W-1:0] m_s;
    logic         m_co;
    logic [W:0]   m_pend;
    logic [W-1:0] m_bop;
    logic         m_cin;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_left = 0;
            m_busy = 1'b0;
            m_done = 1'b0;
            m_s    = '0;
            m_co   = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_busy      = 1'b0;
                    m_done      = 1'b1;
                    {m_co, m_s} = m_pend;
                end
            end else if (start) begin
                m_bop  = sub ? ~b : b;
                m_cin  = sub ? 1'b1 : ci;
                m_pend = {1'b0, a} + {1'b0, m_bop} + {{W{1'b0}}, m_cin};
                m_left = W;
                m_busy = 1'b1;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        check("cyc_busy", 32'(busy), 32'(m_busy));
        check("cyc_done", 32'(done), 32'(m_done));
        check("cyc_s",    32'(s),    32'(m_s));
        check("cyc_co",   32'(co),   32'(m_co));
    end

    // Counts edges after the accepting edge until done is seen (bounded).
    task automatic wait_done(output int k);
        for (k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (done) break;
        end
    endtask

    task automatic run_op(input string nm, input logic [W-1:0] ia, input logic [W-1:0] ib,
                          input logic ici, input logic isub,
                          input logic [W-1:0] es, input logic eco);
        int k;
        @(negedge clk);
        a = ia; b = ib; ci = ici; sub = isub; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ci    = ~ci;
        wait_done(k);
        check({nm, "_latency"}, 32'(k), 32'(W));
        check({nm, "_s"}, 32'(s), 32'(es));
        check({nm, "_co"}, 32'(co), 32'(eco));
        @(posedge clk);
        #1;
        check({nm, "_done_1cyc"}, 32'(done), 32'd0);
    endtask

    initial begin
        int k;
        int spurious;
        rst = 1'b0; start = 1'b0; sub = 1'b0; ci = 1'b0; a = '0; b = '0;
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_s",    32'(s),    32'd0);
        check("rst_co",   32'(co),   32'd0);
        rst = 1'b0;

        run_op("add",    4'b0101, 4'b0011, 1'b0, 1'b0, 4'b1000, 1'b0);
        run_op("carry1", 4'b1111, 4'b0001, 1'b0, 1'b0, 4'b0000, 1'b1);
        run_op("carry2", 4'b0111, 4'b1000, 1'b1, 1'b0, 4'b0000, 1'b1);
        run_op("sub1",   4'b0011, 4'b0101, 1'b0, 1'b1, 4'b1110, 1'b0);
        run_op("sub2",   4'b0101, 4'b0011, 1'b1, 1'b1, 4'b0010, 1'b1);

        // Second start while busy must be dropped
        @(negedge clk);
        a = 4'b0101; b = 4'b0011; ci = 1'b0; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        a = 4'b1111; b = 4'b1111; ci = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(k);
        check("busy_ign_latency", 32'(k), 32'(W - 2));
        check("busy_ign_s",  32'(s),  32'b1000);
        check("busy_ign_co", 32'(co), 32'd0);
        repeat (W + 2) @(posedge clk);
        #1;
        check("busy_ign_idle", 32'(busy), 32'd0);

        // Back-to-back with start held: second op accepted in DONE
        @(negedge clk);
        a = 4'b0101; b = 4'b0011; ci = 1'b0; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        a = 4'b0011; b = 4'b0101; sub = 1'b1;
        wait_done(k);
        check("b2b1_latency", 32'(k), 32'(W));
        check("b2b1_s",  32'(s),  32'b1000);
        check("b2b1_co", 32'(co), 32'd0);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check("b2b2_busy", 32'(busy), 32'd1);
        wait_done(k);
        check("b2b2_latency", 32'(k), 32'(W));
        check("b2b2_s",  32'(s),  32'b1110);
        check("b2b2_co", 32'(co), 32'd0);

        // Reset in the middle of RUN aborts without done
        @(negedge clk);
        a = 4'b0110; b = 4'b0111; ci = 1'b0; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_s",    32'(s),    32'd0);
        check("abort_co",   32'(co),   32'd0);
        @(negedge clk);
        rst = 1'b0;
        spurious = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (done) spurious++;
        end
        check("abort_no_done", 32'(spurious), 32'd0);

        run_op("after_rst", 4'b0110, 4'b0111, 1'b1, 1'b0, 4'b1110, 1'b0);

        repeat (2) @(posedge clk);
        #2;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_serial_add_ctrl

`default_nettype wire
